// File: rtl/irig_tx_pkg.sv
// Shared types and constants for the IRIG-B time frame transmitter.
// TIME_FRAME_CHECKSUM_EN adds the CKS state and lengthens the frame by one byte.
package irig_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
`ifdef TIME_FRAME_CHECKSUM_EN
    CKS,
`endif
    CR,
    LF
  } state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  localparam int NUM_DIGITS = 25;

`ifdef TIME_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_DIGITS + 4;
`else
  localparam int FRAME_LEN = NUM_DIGITS + 3;
`endif

endpackage

// File: rtl/time_frame_tx_bcd_ascii_conv.sv
// Converts one BCD digit (0..9) to its ASCII character; any other value maps to BAD_DIGIT.
module bcd_ascii_conv
  import irig_tx_pkg::*;
#(
  parameter logic [7:0] BAD_DIGIT = 8'h3F
) (
  input  logic [7:0] digit,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = (digit <= 8'd9) ? (digit + ASCII_ZERO) : BAD_DIGIT;
  end

endmodule

// File: rtl/time_frame_tx.sv
// Serialises a captured 25-digit IRIG-B time snapshot into an ASCII frame: '$', digits, [checksum], CR, LF.
// Build macro TIME_FRAME_CHECKSUM_EN inserts an XOR checksum byte of the payload before CR.
module time_frame_tx
  import irig_tx_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE = 8'h24,
  parameter logic [7:0] BAD_DIGIT   = 8'h3F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] time_array [NUM_DIGITS],
  input  logic       time_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic [7:0] drop_cnt,
  output state_t     state_dbg
);

  // Handshake: a byte moves when tx_valid && tx_ready in the same cycle; while
  // tx_valid is high and tx_ready low, tx_data and tx_valid do not change.

  localparam logic [4:0] LAST_IDX = 5'(NUM_DIGITS - 1);

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] shadow_q [NUM_DIGITS];
  logic [7:0] shadow_d [NUM_DIGITS];
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       busy_q, busy_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
`ifdef TIME_FRAME_CHECKSUM_EN
  logic [7:0] cks_q, cks_d;
`endif

  logic       xfer;
  logic       accept;
  logic [4:0] next_idx;
  logic [7:0] conv_ascii;

  assign xfer   = tx_valid_q && tx_ready;
  // A new snapshot is taken when idle, or in the very cycle the LF byte leaves.
  assign accept = time_valid && ((state_q == IDLE) || ((state_q == LF) && xfer));

  // The converter looks ahead at the entry that will be presented after this transfer.
  assign next_idx = ((state_q == PAY) && (idx_q != LAST_IDX)) ? (idx_q + 5'd1) : 5'd0;

  bcd_ascii_conv #(
    .BAD_DIGIT(BAD_DIGIT)
  ) u_conv (
    .digit(shadow_q[next_idx]),
    .ascii(conv_ascii)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    tx_data_d  = tx_data_q;
    drop_cnt_d = drop_cnt_q;
`ifdef TIME_FRAME_CHECKSUM_EN
    cks_d      = cks_q;
`endif

    if (xfer) begin
      unique case (state_q)
        HDR: begin
          state_d   = PAY;
          idx_d     = 5'd0;
          tx_data_d = conv_ascii;
        end
        PAY: begin
`ifdef TIME_FRAME_CHECKSUM_EN
          cks_d = cks_q ^ tx_data_q;
`endif
          if (idx_q == LAST_IDX) begin
            idx_d = 5'd0;
`ifdef TIME_FRAME_CHECKSUM_EN
            state_d   = CKS;
            tx_data_d = cks_q ^ tx_data_q;
`else
            state_d   = CR;
            tx_data_d = ASCII_CR;
`endif
          end else begin
            idx_d     = next_idx;
            tx_data_d = conv_ascii;
          end
        end
`ifdef TIME_FRAME_CHECKSUM_EN
        CKS: begin
          state_d   = CR;
          tx_data_d = ASCII_CR;
        end
`endif
        CR: begin
          state_d   = LF;
          tx_data_d = ASCII_LF;
        end
        LF: begin
          state_d = IDLE;
        end
        default: ;
      endcase
    end

    if (accept) begin
      state_d   = HDR;
      idx_d     = 5'd0;
      shadow_d  = time_array;
      tx_data_d = HEADER_BYTE;
`ifdef TIME_FRAME_CHECKSUM_EN
      cks_d     = 8'h00;
`endif
    end else if (time_valid && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    tx_valid_d = (state_d != IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 5'd0;
      shadow_q   <= '{default: 8'h00};
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_cnt_q <= 8'h00;
`ifdef TIME_FRAME_CHECKSUM_EN
      cks_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef TIME_FRAME_CHECKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_time_frame_tx.sv
// Scoreboard bench for time_frame_tx: drivers push expected frame bytes, a negedge monitor pops and compares.
module tb_time_frame_tx;

  localparam logic [7:0] HDR_B = 8'h24;
  localparam logic [7:0] BAD_B = 8'h3F;
`ifdef TIME_FRAME_CHECKSUM_EN
  localparam int FLEN = 29;
`else
  localparam int FLEN = 28;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] digits [25];
  logic       time_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic [7:0] drop_cnt;
  irig_tx_pkg::state_t state_dbg;

  time_frame_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .time_array(digits),
    .time_valid(time_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .drop_cnt  (drop_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / ready pattern ----------------
  always #5 clk = ~clk;

  int rdy_mode = 0;  // 0: always ready, 1: toggle each cycle, 2: never ready
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) tx_ready = ~tx_ready;
    else if (rdy_mode == 2) tx_ready = 1'b0;
    else tx_ready = 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int n_rx  = 0;
  logic [7:0] exp_drop = 8'h00;
  string frame_a_str = "$0000020250123000014030059";
  int unsigned frame_a [25] = '{0,0,0,0,0,2,0,2,5,0,1,2,3,0,0,0,0,1,4,0,3,0,0,5,9};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_data", tx_data, prev_data);
        check("stall_hold_valid", {7'd0, tx_valid}, 8'd1);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_byte: got %02h expected none (t=%0t)", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("byte%0d", n_rx), tx_data, e);
        end
        n_rx++;
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame_a();
    for (int i = 0; i < 25; i++) digits[i] = 8'(frame_a[i]);
  endtask

  // Expected bytes: frame A from the hand-written string, others from the digit rule.
  task automatic push_frame(input bit use_ref);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(HDR_B);
    for (int i = 0; i < 25; i++) begin
      if (use_ref) b = frame_a_str[i+1];
      else b = (digits[i] <= 8'd9) ? (digits[i] + 8'h30) : BAD_B;
      x = x ^ b;
      exp_q.push_back(b);
    end
`ifdef TIME_FRAME_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Called at posedge+1 of cycle N; returns at posedge+1 of cycle N+1.
  task automatic start_frame(input bit use_ref);
    push_frame(use_ref);
    time_valid = 1'b1;
    tick();
    time_valid = 1'b0;
    check("hdr_valid", {7'd0, tx_valid}, 8'd1);
    check("hdr_data", tx_data, HDR_B);
    for (int i = 0; i < 25; i++) digits[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || tx_valid) && c < budget) begin
      tick();
      c++;
    end
    n_vec++;
    if (c >= budget) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d bytes left expected 0", exp_q.size());
    end
    check("idle_busy", {7'd0, busy}, 8'd0);
    check("idle_valid", {7'd0, tx_valid}, 8'd0);
    check("drop_cnt", drop_cnt, exp_drop);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 25; i++) digits[i] = 8'h00;
    #3;
    check("rst_valid", {7'd0, tx_valid}, 8'd0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_drop", drop_cnt, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Reference frame, always ready
    set_frame_a();
    start_frame(1'b1);
    wait_drain(200);

    // Same frame, ready toggling
    rdy_mode = 1;
    tick();
    set_frame_a();
    start_frame(1'b1);
    wait_drain(300);
    rdy_mode = 0;
    tick();
    tick();

    // Out-of-range digit at position 7
    set_frame_a();
    digits[7] = 8'd12;
    start_frame(1'b0);
    wait_drain(200);

    // Back-to-back: new time_valid in the LF transfer cycle
    set_frame_a();
    start_frame(1'b1);
    repeat (FLEN - 1) tick();
    check("lf_present", tx_data, 8'h0A);
    check("lf_ready", {7'd0, tx_ready}, 8'd1);
    digits[3] = 8'd7;
    digits[20] = 8'hA5;
    start_frame(1'b0);
    check("b2b_drop", drop_cnt, exp_drop);
    wait_drain(200);

    // Three drops during one frame
    set_frame_a();
    start_frame(1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      time_valid = 1'b1;
      tick();
      time_valid = 1'b0;
      tick();
    end
    exp_drop = 8'd3;
    check("drop3", drop_cnt, exp_drop);
    wait_drain(200);

    // 260 more drops while stalled -> saturate
    rdy_mode = 2;
    tick();
    tick();
    digits[0] = 8'd9;
    start_frame(1'b0);
    time_valid = 1'b1;
    repeat (260) tick();
    time_valid = 1'b0;
    exp_drop = 8'hFF;
    check("drop_sat", drop_cnt, exp_drop);
    check("stalled_valid", {7'd0, tx_valid}, 8'd1);
    rdy_mode = 0;
    wait_drain(200);

    // Reset in the middle of payload index 10
    set_frame_a();
    start_frame(1'b1);
    repeat (11) tick();
    check("pay10_data", tx_data, 8'h31);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {7'd0, tx_valid}, 8'd0);
    check("mid_rst_data", tx_data, 8'h00);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_drop", drop_cnt, 8'h00);
    exp_q.delete();
    exp_drop = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_idle", {7'd0, tx_valid}, 8'd0);
    end
    set_frame_a();
    start_frame(1'b1);
    wait_drain(200);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expected: got %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
